// File: rtl/lsu_ahb_master_pkg.sv
// lsu_ahb_pkg: shared types and the alignment check for the LSU AHB-Lite master.
package lsu_ahb_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_NONSEQ = 2'b10
    } htrans_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_t;

    // Size 2'b11 is never legal; otherwise the address must be naturally aligned.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return (size == 2'b11) || (size == SZ_HALF && addr_lo[0]) || (size == SZ_WORD && addr_lo != 2'b00);
    endfunction

endpackage

// File: rtl/lsu_ahb_master_if.sv
// lsu_ahb_master_if: CPU request/response channel plus AHB-Lite master signals.
interface lsu_ahb_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [DATA_W-1:0] HWDATA;
    logic [DATA_W-1:0] HRDATA;
    logic              HREADY;
    logic              HRESP;

    modport master (
        input  req_valid, req_write, req_size, req_addr, req_wdata, HRDATA, HREADY, HRESP,
        output req_ready, resp_valid, resp_rdata, resp_err, HADDR, HTRANS, HWRITE, HSIZE, HWDATA
    );

    modport slave (
        output req_valid, req_write, req_size, req_addr, req_wdata, HRDATA, HREADY, HRESP,
        input  req_ready, resp_valid, resp_rdata, resp_err, HADDR, HTRANS, HWRITE, HSIZE, HWDATA
    );
endinterface

// File: rtl/lsu_ahb_master_lane_align.sv
// lsu_lane_align: store-data lane replication and load-data extraction for a 32-bit bus.
module lsu_lane_align
    import lsu_ahb_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);
    logic [31:0] shifted;

    always_comb begin
        shifted = rdata_i >> {addr_lo_i, 3'b000};
        wdata_o = size_i == SZ_BYTE ? {4{wdata_i[7:0]}} : size_i == SZ_HALF ? {2{wdata_i[15:0]}} : wdata_i;
        rdata_o = size_i == SZ_BYTE ? {24'b0, shifted[7:0]} : size_i == SZ_HALF ? {16'b0, shifted[15:0]} : shifted;
    end
endmodule

// File: rtl/lsu_ahb_master.sv
// lsu_ahb_master: single-outstanding CPU load/store to AHB-Lite NONSEQ master.
// Define LSU_TIMEOUT_EN to abort DATA-phase waits after TIMEOUT_CYCLES with an error.
module lsu_ahb_master
    import lsu_ahb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input logic              clk,
    input logic              reset_n,
    lsu_ahb_master_if.master bus
);
    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] ADDR = ST_ADDR;
    localparam logic [1:0] DATA = ST_DATA;
    localparam logic [1:0] RESP = ST_RESP;

    logic [1:0]        state_q, state_d;
    logic [1:0]        htrans_q, htrans_d;
    logic [ADDR_W-1:0] haddr_q, haddr_d;
    logic              hwrite_q, hwrite_d;
    logic [1:0]        size_q, size_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] hwdata_q, hwdata_d;
    logic [DATA_W-1:0] pend_rdata_q, pend_rdata_d;
    logic              pend_err_q, pend_err_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic [31:0]       wdata_rep, rdata_al;
    logic              timeout;

    lsu_lane_align u_align (
        .size_i   (size_q),
        .addr_lo_i(haddr_q[1:0]),
        .wdata_i  (wdata_q),
        .rdata_i  (bus.HRDATA),
        .wdata_o  (wdata_rep),
        .rdata_o  (rdata_al)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter is zero whenever we are not stalled in DATA, so it is clear on DATA entry.
    assign cnt_d   = (state_q == DATA && !bus.HREADY) ? cnt_q + 1'b1 : '0;
    assign timeout = cnt_q == CW'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        htrans_d     = htrans_q;
        haddr_d      = haddr_q;
        hwrite_d     = hwrite_q;
        size_d       = size_q;
        wdata_d      = wdata_q;
        hwdata_d     = hwdata_q;
        pend_rdata_d = pend_rdata_q;
        pend_err_d   = pend_err_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            IDLE: if (bus.req_valid) begin
                if (misaligned(bus.req_size, bus.req_addr[1:0])) begin
                    state_d      = RESP;
                    pend_err_d   = 1'b1;
                    pend_rdata_d = '0;
                end else begin
                    state_d  = ADDR;
                    htrans_d = HT_NONSEQ;
                    haddr_d  = bus.req_addr;
                    hwrite_d = bus.req_write;
                    size_d   = bus.req_size;
                    wdata_d  = bus.req_wdata;
                end
            end
            ADDR: if (bus.HREADY) begin
                state_d  = DATA;
                htrans_d = HT_IDLE;
                hwdata_d = hwrite_q ? wdata_rep : hwdata_q;
            end
            DATA: if (bus.HREADY) begin
                state_d      = RESP;
                pend_err_d   = bus.HRESP;
                pend_rdata_d = (bus.HRESP || hwrite_q) ? '0 : rdata_al;
            end else if (timeout) begin
                state_d      = RESP;
                pend_err_d   = 1'b1;
                pend_rdata_d = '0;
            end
            default: begin
                state_d      = IDLE;
                resp_valid_d = 1'b1;
                resp_rdata_d = pend_rdata_q;
                resp_err_d   = pend_err_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            htrans_q     <= HT_IDLE;
            haddr_q      <= '0;
            hwrite_q     <= 1'b0;
            size_q       <= 2'b00;
            wdata_q      <= '0;
            hwdata_q     <= '0;
            pend_rdata_q <= '0;
            pend_err_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            htrans_q     <= htrans_d;
            haddr_q      <= haddr_d;
            hwrite_q     <= hwrite_d;
            size_q       <= size_d;
            wdata_q      <= wdata_d;
            hwdata_q     <= hwdata_d;
            pend_rdata_q <= pend_rdata_d;
            pend_err_q   <= pend_err_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign bus.req_ready  = state_q == IDLE;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.HADDR      = haddr_q;
    assign bus.HTRANS     = htrans_q;
    assign bus.HWRITE     = hwrite_q;
    assign bus.HSIZE      = {1'b0, size_q};
    assign bus.HWDATA     = hwdata_q;
endmodule

// File: tb/tb_lsu_ahb_master.sv
// tb_lsu_ahb_master: directed self-checking bench for lsu_ahb_master.
// Define LSU_TIMEOUT_EN to also exercise the DATA-phase timeout with TIMEOUT_CYCLES=8.
module tb_lsu_ahb_master;
`ifdef LSU_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 256;
`endif

    logic clk = 1'b0;
    logic reset_n;
    int   total = 0;
    int   passed = 0;
    int   pulses;

    always #5 clk = ~clk;

    lsu_ahb_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    lsu_ahb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic req(input logic w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_size  = sz;
        bus.req_addr  = a;
        bus.req_wdata = d;
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_size  = 2'b00;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.HRDATA    = '0;
        bus.HREADY    = 1'b1;
        bus.HRESP     = 1'b0;
        #3;
        chk("rst_htrans", 32'(bus.HTRANS), 0);
        chk("rst_haddr", bus.HADDR, 0);
        chk("rst_hwrite", 32'(bus.HWRITE), 0);
        chk("rst_hsize", 32'(bus.HSIZE), 0);
        chk("rst_hwdata", bus.HWDATA, 0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 0);
        chk("rst_resp_rdata", bus.resp_rdata, 0);
        chk("rst_resp_err", 32'(bus.resp_err), 0);
        chk("rst_req_ready", 32'(bus.req_ready), 1);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Word store 0x10; a different request held during ADDR must be ignored
        req(1'b1, 2'b10, 32'h10, 32'hDEADBEEF);
        tick();
        chk("ws_htrans", 32'(bus.HTRANS), 2);
        chk("ws_haddr", bus.HADDR, 32'h10);
        chk("ws_hwrite", 32'(bus.HWRITE), 1);
        chk("ws_hsize", 32'(bus.HSIZE), 2);
        chk("ws_req_ready", 32'(bus.req_ready), 0);
        req(1'b0, 2'b00, 32'h99, 32'h0);
        tick();
        bus.req_valid = 1'b0;
        chk("ws_data_htrans", 32'(bus.HTRANS), 0);
        chk("ws_hwdata", bus.HWDATA, 32'hDEADBEEF);
        chk("ws_haddr_ignored", bus.HADDR, 32'h10);
        tick();
        chk("ws_no_early_resp", 32'(bus.resp_valid), 0);
        tick();
        chk("ws_resp_valid", 32'(bus.resp_valid), 1);
        chk("ws_resp_err", 32'(bus.resp_err), 0);
        chk("ws_req_ready_back", 32'(bus.req_ready), 1);
        tick();
        chk("ws_resp_pulse", 32'(bus.resp_valid), 0);

        // Byte load 0x13
        req(1'b0, 2'b00, 32'h13, 32'h0);
        tick();
        bus.req_valid = 1'b0;
        chk("bl_hsize", 32'(bus.HSIZE), 0);
        chk("bl_htrans", 32'(bus.HTRANS), 2);
        bus.HRDATA = 32'hAABBCCDD;
        tick();
        tick();
        tick();
        chk("bl_resp_valid", 32'(bus.resp_valid), 1);
        chk("bl_resp_rdata", bus.resp_rdata, 32'h000000AA);
        chk("bl_resp_err", 32'(bus.resp_err), 0);
        tick();
        chk("bl_rdata_held", bus.resp_rdata, 32'h000000AA);

        // Word load 0x40 with a two-cycle ERROR response
        req(1'b0, 2'b10, 32'h40, 32'h0);
        tick();
        bus.req_valid = 1'b0;
        bus.HRDATA = 32'h12345678;
        tick();
        bus.HREADY = 1'b0;
        bus.HRESP  = 1'b1;
        tick();
        chk("er_wait_no_resp", 32'(bus.resp_valid), 0);
        chk("er_wait_busy", 32'(bus.req_ready), 0);
        bus.HREADY = 1'b1;
        tick();
        bus.HRESP = 1'b0;
        tick();
        chk("er_resp_valid", 32'(bus.resp_valid), 1);
        chk("er_resp_err", 32'(bus.resp_err), 1);
        chk("er_resp_rdata", bus.resp_rdata, 0);
        tick();

        // Half store 0x22 with two DATA wait states
        req(1'b1, 2'b01, 32'h22, 32'h00001234);
        tick();
        bus.req_valid = 1'b0;
        chk("hs_hsize", 32'(bus.HSIZE), 1);
        tick();
        bus.HREADY = 1'b0;
        chk("hs_hwdata_c1", bus.HWDATA, 32'h12341234);
        tick();
        chk("hs_hwdata_c2", bus.HWDATA, 32'h12341234);
        chk("hs_wait_no_resp", 32'(bus.resp_valid), 0);
        tick();
        chk("hs_hwdata_c3", bus.HWDATA, 32'h12341234);
        bus.HREADY = 1'b1;
        tick();
        chk("hs_no_early_resp", 32'(bus.resp_valid), 0);
        tick();
        chk("hs_resp_valid", 32'(bus.resp_valid), 1);
        chk("hs_resp_err", 32'(bus.resp_err), 0);
        chk("hs_resp_rdata", bus.resp_rdata, 0);
        tick();

        // Misaligned word load 0x06: no bus transfer, error response next cycle
        req(1'b0, 2'b10, 32'h06, 32'h0);
        tick();
        bus.req_valid = 1'b0;
        chk("ma_htrans_0", 32'(bus.HTRANS), 0);
        chk("ma_busy", 32'(bus.req_ready), 0);
        tick();
        chk("ma_htrans_1", 32'(bus.HTRANS), 0);
        chk("ma_resp_valid", 32'(bus.resp_valid), 1);
        chk("ma_resp_err", 32'(bus.resp_err), 1);
        chk("ma_resp_rdata", bus.resp_rdata, 0);
        tick();
        chk("ma_err_held", 32'(bus.resp_err), 1);

        // Illegal size on a load
        req(1'b0, 2'b11, 32'h0, 32'h0);
        tick();
        bus.req_valid = 1'b0;
        chk("il_htrans", 32'(bus.HTRANS), 0);
        tick();
        chk("il_resp_valid", 32'(bus.resp_valid), 1);
        chk("il_resp_err", 32'(bus.resp_err), 1);
        tick();

`ifdef LSU_TIMEOUT_EN
        req(1'b0, 2'b10, 32'h100, 32'h0);
        tick();
        bus.req_valid = 1'b0;
        tick();
        bus.HREADY = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("to_still_waiting", 32'(bus.req_ready), 0);
        tick();
        chk("to_no_resp_yet", 32'(bus.resp_valid), 0);
        tick();
        chk("to_resp_valid", 32'(bus.resp_valid), 1);
        chk("to_resp_err", 32'(bus.resp_err), 1);
        chk("to_resp_rdata", bus.resp_rdata, 0);
        chk("to_idle", 32'(bus.req_ready), 1);
        bus.HREADY = 1'b1;
        tick();
`endif

        // ADDR held by HREADY=0, then reset aborts the transfer
        req(1'b1, 2'b10, 32'h80, 32'hCAFEF00D);
        tick();
        bus.req_valid = 1'b0;
        bus.HREADY = 1'b0;
        tick();
        chk("ah_htrans_held", 32'(bus.HTRANS), 2);
        chk("ah_haddr_held", bus.HADDR, 32'h80);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_htrans", 32'(bus.HTRANS), 0);
        chk("ar_req_ready", 32'(bus.req_ready), 1);
        chk("ar_resp_valid", 32'(bus.resp_valid), 0);
        bus.HREADY = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.resp_valid) pulses++;
        end
        chk("ar_no_resp_after", 32'(pulses), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
